// File: rtl/simple_uart_pkg.sv
// simple_uart shared definitions: register map, frame constants, FSM states.
// No ports; imported by the interface, the receiver and the top level.
package simple_uart_pkg;

   localparam int UART_ADDR_W = 3;

   localparam logic [UART_ADDR_W-1:0] UART_SOFTRESET = 3'd0;
   localparam logic [UART_ADDR_W-1:0] UART_DIV       = 3'd1;
   localparam logic [UART_ADDR_W-1:0] UART_TXDATA    = 3'd2;
   localparam logic [UART_ADDR_W-1:0] UART_TXEN      = 3'd3;
   localparam logic [UART_ADDR_W-1:0] UART_RXEN      = 3'd4;
   localparam logic [UART_ADDR_W-1:0] UART_TXREADY   = 3'd5;
   localparam logic [UART_ADDR_W-1:0] UART_RXSTAT    = 3'd6;
   localparam logic [UART_ADDR_W-1:0] UART_RXDATA    = 3'd7;

   localparam int FRAME_BITS = 10;
   localparam int DIV_MIN    = 4;

   // start + stop bracket the payload
   localparam int DATA_BITS = FRAME_BITS - 2;
   localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_e;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_e;

endpackage

// File: rtl/simple_uart_if.sv
// Native valid/ready peripheral bus between CPU (master) and UART (slave).
// valid/address/wdata/wstrb from master; rdata/ready back from slave.
interface simple_uart_if #(
   parameter int ADDR_W = simple_uart_pkg::UART_ADDR_W,
   parameter int DATA_W = 32
);

   logic              valid;
   logic [ADDR_W-1:0] address;
   logic [DATA_W-1:0] wdata;
   logic              wstrb;
   logic [DATA_W-1:0] rdata;
   logic              ready;

   modport master (
      output valid, address, wdata, wstrb,
      input  rdata, ready
   );

   modport slave (
      input  valid, address, wdata, wstrb,
      output rdata, ready
   );

endinterface

// File: rtl/simple_uart_rx.sv
// 8N1 receiver: 2-flop synchronizer, start-edge qualify, centre sampling.
// Ports: clk, reset, clr (abort), en, div (effective), rxd in; rx_byte, done out.
module simple_uart_rx
   import simple_uart_pkg::*;
#(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   input  logic [DIV_W-1:0] div,
   input  logic             rxd,
   output logic [7:0]       rx_byte,
   output logic             done
);

   logic sync1_q;
   logic sync2_q;
   logic prev_q;

   rx_state_e state_q, state_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       sh_q, sh_d;

   logic bit_end;
   logic half_end;

   assign bit_end  = cnt_q >= div - DIV_W'(1);
   assign half_end = cnt_q >= (div >> 1) - DIV_W'(1);

   // synchronizer plus one flop of history for edge detection
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
      end else begin
         sync1_q <= rxd;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RX_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + DIV_W'(1);
      bit_d   = bit_q;
      sh_d    = sh_q;
      unique case (state_q)
         RX_IDLE: begin
            cnt_d = '0;
            bit_d = '0;
            if (en && prev_q && !sync2_q) begin
               state_d = RX_START;
            end
         end
         RX_START: begin
            // high at mid start bit means the edge was a glitch
            if (half_end) begin
               cnt_d   = '0;
               state_d = sync2_q ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (bit_end) begin
               cnt_d = '0;
               sh_d  = {sync2_q, sh_q[7:1]};
               if (bit_q == LAST_BIT) begin
                  state_d = RX_STOP;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end
         end
         RX_STOP: begin
            if (bit_end) begin
               cnt_d   = '0;
               state_d = RX_IDLE;
            end
         end
         default: state_d = RX_IDLE;
      endcase
      if (clr || !en) begin
         state_d = RX_IDLE;
         cnt_d   = '0;
         bit_d   = '0;
      end
   end

   // a low stop sample is a framing error: no strobe
   always_comb begin
      done    = (state_q == RX_STOP) && bit_end && sync2_q && en && !clr;
      rx_byte = sh_q;
   end

endmodule

// File: rtl/simple_uart.sv
// Memory-mapped 8N1 UART: register file, transmitter, receiver instance.
// Ports: clk, reset, bus (valid/ready slave), txd out, rxd in (async).
module simple_uart
   import simple_uart_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = UART_ADDR_W,
   parameter int DIV_W  = 16
) (
   input  logic         clk,
   input  logic         reset,
   simple_uart_if.slave bus,
   output logic         txd,
   input  logic         rxd
);

   logic              ready_q, ready_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              wstrb_q, wstrb_d;

   logic [DIV_W-1:0] div_q, div_d;
   logic             txen_q, txen_d;
   logic             rxen_q, rxen_d;
   logic             rx_ready_q, rx_ready_d;
   logic             overrun_q, overrun_d;
   logic [7:0]       rx_data_q, rx_data_d;

   tx_state_e        tx_state_q, tx_state_d;
   logic [DIV_W-1:0] tx_cnt_q, tx_cnt_d;
   logic [2:0]       tx_bit_q, tx_bit_d;
   logic [7:0]       tx_sh_q, tx_sh_d;
   logic             tx_ready;

   logic [DIV_W-1:0] div_eff;
   logic             tx_bit_end;
   logic             wr_en, rd_en;
   logic             wr_soft, wr_div, wr_tx, wr_txen, wr_rxen;
   logic             rd_stat, rd_data;
   logic             tx_go, tx_abort, rx_clr;
   logic             rx_done;
   logic [7:0]       rx_byte;

   logic unused_wdata;
   assign unused_wdata = ^wdata_q[DATA_W-1:DIV_W];

   assign div_eff = (div_q < DIV_W'(DIV_MIN)) ? DIV_W'(DIV_MIN) : div_q;

   // writes act in the ready cycle from the captured request
   assign wr_en   = ready_q && wstrb_q;
   assign wr_soft = wr_en && addr_q == ADDR_W'(UART_SOFTRESET) && wdata_q[0];
   assign wr_div  = wr_en && addr_q == ADDR_W'(UART_DIV);
   assign wr_tx   = wr_en && addr_q == ADDR_W'(UART_TXDATA);
   assign wr_txen = wr_en && addr_q == ADDR_W'(UART_TXEN);
   assign wr_rxen = wr_en && addr_q == ADDR_W'(UART_RXEN);

   // reads sample (and clear flags) in the request cycle
   assign rd_en   = bus.valid && !bus.wstrb;
   assign rd_stat = rd_en && bus.address == ADDR_W'(UART_RXSTAT);
   assign rd_data = rd_en && bus.address == ADDR_W'(UART_RXDATA);

   assign tx_go    = wr_tx && txen_q && tx_ready;
   assign tx_abort = wr_soft || (wr_txen && !wdata_q[0]);
   assign rx_clr   = wr_soft || (wr_rxen && !wdata_q[0]);

   assign bus.ready = ready_q;
   assign bus.rdata = rdata_q;

   simple_uart_rx #(
      .DIV_W(DIV_W)
   ) u_rx (
      .clk    (clk),
      .reset  (reset),
      .clr    (rx_clr),
      .en     (rxen_q),
      .div    (div_eff),
      .rxd    (rxd),
      .rx_byte(rx_byte),
      .done   (rx_done)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         ready_q    <= 1'b0;
         rdata_q    <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         wstrb_q    <= 1'b0;
         div_q      <= '0;
         txen_q     <= 1'b0;
         rxen_q     <= 1'b0;
         rx_ready_q <= 1'b0;
         overrun_q  <= 1'b0;
         rx_data_q  <= '0;
      end else begin
         ready_q    <= ready_d;
         rdata_q    <= rdata_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         div_q      <= div_d;
         txen_q     <= txen_d;
         rxen_q     <= rxen_d;
         rx_ready_q <= rx_ready_d;
         overrun_q  <= overrun_d;
         rx_data_q  <= rx_data_d;
      end
   end

   always_comb begin
      ready_d = bus.valid;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wstrb_d = wstrb_q;
      if (bus.valid) begin
         addr_d  = bus.address;
         wdata_d = bus.wdata;
         wstrb_d = bus.wstrb;
      end

      rdata_d = '0;
      if (rd_en) begin
         case (bus.address)
            ADDR_W'(UART_DIV):     rdata_d = DATA_W'(div_q);
            ADDR_W'(UART_TXEN):    rdata_d = DATA_W'(txen_q);
            ADDR_W'(UART_RXEN):    rdata_d = DATA_W'(rxen_q);
            ADDR_W'(UART_TXREADY): rdata_d = DATA_W'(tx_ready);
            ADDR_W'(UART_RXSTAT):  rdata_d = DATA_W'({overrun_q, rx_ready_q});
            ADDR_W'(UART_RXDATA):  rdata_d = DATA_W'(rx_data_q);
            default:               rdata_d = '0;
         endcase
      end

      div_d  = wr_div ? wdata_q[DIV_W-1:0] : div_q;
      txen_d = wr_txen ? wdata_q[0] : txen_q;
      rxen_d = wr_rxen ? wdata_q[0] : rxen_q;

      rx_ready_d = rx_ready_q && !rd_data;
      overrun_d  = overrun_q && !rd_stat;
      rx_data_d  = rx_data_q;
      if (rx_done) begin
         rx_data_d  = rx_byte;
         rx_ready_d = 1'b1;
         // a same-cycle RXDATA read consumed the old byte
         if (rx_ready_q && !rd_data) begin
            overrun_d = 1'b1;
         end
      end

      if (wr_soft) begin
         txen_d     = 1'b0;
         rxen_d     = 1'b0;
         rx_ready_d = 1'b0;
         overrun_d  = 1'b0;
         rx_data_d  = '0;
      end
   end

   // transmitter: state register
   always_ff @(posedge clk) begin
      if (reset) begin
         tx_state_q <= TX_IDLE;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_sh_q    <= '0;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_sh_q    <= tx_sh_d;
      end
   end

   assign tx_bit_end = tx_cnt_q >= div_eff - DIV_W'(1);

   // transmitter: next state
   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q + DIV_W'(1);
      tx_bit_d   = tx_bit_q;
      tx_sh_d    = tx_sh_q;
      unique case (tx_state_q)
         TX_IDLE: begin
            tx_cnt_d = '0;
            if (tx_go) begin
               tx_state_d = TX_START;
               tx_bit_d   = '0;
               tx_sh_d    = wdata_q[7:0];
            end
         end
         TX_START: begin
            if (tx_bit_end) begin
               tx_cnt_d   = '0;
               tx_state_d = TX_DATA;
            end
         end
         TX_DATA: begin
            if (tx_bit_end) begin
               tx_cnt_d = '0;
               if (tx_bit_q == LAST_BIT) begin
                  tx_state_d = TX_STOP;
               end else begin
                  tx_bit_d = tx_bit_q + 3'd1;
               end
            end
         end
         TX_STOP: begin
            if (tx_bit_end) begin
               tx_cnt_d   = '0;
               tx_state_d = TX_IDLE;
            end
         end
         default: tx_state_d = TX_IDLE;
      endcase
      if (tx_abort) begin
         tx_state_d = TX_IDLE;
         tx_cnt_d   = '0;
      end
   end

   // transmitter: outputs
   always_comb begin
      txd      = 1'b1;
      tx_ready = 1'b0;
      unique case (tx_state_q)
         TX_IDLE:  tx_ready = 1'b1;
         TX_START: txd = 1'b0;
         TX_DATA:  txd = tx_sh_q[tx_bit_q];
         TX_STOP:  txd = 1'b1;
         default:  txd = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_simple_uart.sv
// Directed bench for simple_uart: register table plus TX/RX frame sequences.
// Drives the bus interface and rxd, checks rdata, ready and txd.
module tb_simple_uart;

   logic clk;
   logic reset;
   logic txd;
   logic rxd;
   logic rxd_drv;
   logic loopback;

   int checks;
   int errors;

   simple_uart_if bus ();

   assign rxd = loopback ? txd : rxd_drv;

   simple_uart dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus),
      .txd  (txd),
      .rxd  (rxd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   typedef struct {
      logic [2:0]  addr;
      logic        wr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   localparam int NVEC = 25;
   vec_t vecs[NVEC];

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, got, exp);
      end
   endtask

   // call with time just after a posedge; returns just after a posedge
   task automatic cpu_access(input logic [2:0] a, input logic w,
                             input logic [31:0] d, output logic [31:0] r);
      bus.valid   = 1'b1;
      bus.address = a;
      bus.wdata   = d;
      bus.wstrb   = w;
      @(posedge clk);
      #1;
      bus.valid = 1'b0;
      r = bus.rdata;
      chk("ready_high", 32'(bus.ready), 32'd1);
      @(posedge clk);
      #1;
      chk("ready_low", 32'(bus.ready), 32'd0);
   endtask

   task automatic cpu_write(input logic [2:0] a, input logic [31:0] d);
      logic [31:0] r;
      cpu_access(a, 1'b1, d, r);
   endtask

   task automatic cpu_read(input logic [2:0] a, input logic [31:0] exp,
                           input string name);
      logic [31:0] r;
      cpu_access(a, 1'b0, 32'h0, r);
      chk(name, r, exp);
   endtask

   function automatic logic frame_bit(input logic [7:0] d, input int k);
      if (k == 0) return 1'b0;
      if (k >= 9) return 1'b1;
      return d[k-1];
   endfunction

   // DIV = 4: each bit held 4 cycles, line left idle high
   task automatic drive_frame(input logic [7:0] d, input logic stop);
      for (int k = 0; k < 10; k++) begin
         rxd_drv = (k == 9) ? stop : frame_bit(d, k);
         repeat (4) @(posedge clk);
         #1;
      end
      rxd_drv = 1'b1;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] r;
      checks      = 0;
      errors      = 0;
      bus.valid   = 1'b0;
      bus.address = '0;
      bus.wdata   = '0;
      bus.wstrb   = 1'b0;
      rxd_drv     = 1'b1;
      loopback    = 1'b0;
      reset       = 1'b1;

      vecs[0]  = '{3'd5, 1'b0, 32'h0, 32'h1};
      vecs[1]  = '{3'd6, 1'b0, 32'h0, 32'h0};
      vecs[2]  = '{3'd1, 1'b0, 32'h0, 32'h0};
      vecs[3]  = '{3'd3, 1'b0, 32'h0, 32'h0};
      vecs[4]  = '{3'd4, 1'b0, 32'h0, 32'h0};
      vecs[5]  = '{3'd7, 1'b0, 32'h0, 32'h0};
      vecs[6]  = '{3'd1, 1'b1, 32'h12345, 32'h0};
      vecs[7]  = '{3'd1, 1'b0, 32'h0, 32'h2345};
      vecs[8]  = '{3'd3, 1'b1, 32'h1, 32'h0};
      vecs[9]  = '{3'd3, 1'b0, 32'h0, 32'h1};
      vecs[10] = '{3'd3, 1'b1, 32'h0, 32'h0};
      vecs[11] = '{3'd2, 1'b1, 32'hFF, 32'h0};
      vecs[12] = '{3'd5, 1'b0, 32'h0, 32'h1};
      vecs[13] = '{3'd5, 1'b1, 32'h0, 32'h0};
      vecs[14] = '{3'd5, 1'b0, 32'h0, 32'h1};
      vecs[15] = '{3'd4, 1'b1, 32'hFFFF_FFFF, 32'h0};
      vecs[16] = '{3'd4, 1'b0, 32'h0, 32'h1};
      vecs[17] = '{3'd4, 1'b1, 32'h0, 32'h0};
      vecs[18] = '{3'd4, 1'b0, 32'h0, 32'h0};
      vecs[19] = '{3'd6, 1'b1, 32'h3, 32'h0};
      vecs[20] = '{3'd6, 1'b0, 32'h0, 32'h0};
      vecs[21] = '{3'd1, 1'b1, 32'h4, 32'h0};
      vecs[22] = '{3'd1, 1'b0, 32'h0, 32'h4};
      vecs[23] = '{3'd3, 1'b1, 32'h1, 32'h0};
      vecs[24] = '{3'd3, 1'b0, 32'h0, 32'h1};

      @(posedge clk);
      #1;
      reset = 1'b0;
      chk("reset_ready", 32'(bus.ready), 32'd0);
      chk("reset_rdata", bus.rdata, 32'd0);
      chk("reset_txd", 32'(txd), 32'd1);

      for (int i = 0; i < NVEC; i++) begin
         cpu_access(vecs[i].addr, vecs[i].wr, vecs[i].wdata, r);
         if (!vecs[i].wr) chk($sformatf("vec%0d", i), r, vecs[i].exp);
         chk($sformatf("vec%0d_txd", i), 32'(txd), 32'd1);
      end

      // 0x55 frame, mid-frame 0xAA dropped, TXREADY tracked
      cpu_write(3'd2, 32'h55);
      fork
         begin
            for (int c = 0; c < 44; c++) begin
               chk($sformatf("tx55_c%0d", c), 32'(txd),
                   32'(c < 40 ? frame_bit(8'h55, c / 4) : 1'b1));
               wait_cycles(1);
            end
         end
         begin
            cpu_write(3'd2, 32'hAA);
            for (int i = 0; i < 19; i++) cpu_read(3'd5, 32'h0, "txready_busy");
            cpu_read(3'd5, 32'h1, "txready_c41");
         end
      join

      // TXEN cleared mid-frame
      cpu_write(3'd2, 32'hF0);
      wait_cycles(6);
      cpu_write(3'd3, 32'h0);
      chk("abort_txd", 32'(txd), 32'd1);
      cpu_read(3'd5, 32'h1, "abort_txready");
      cpu_read(3'd3, 32'h0, "abort_txen");
      cpu_write(3'd3, 32'h1);

      // loopback 0xA3
      loopback = 1'b1;
      cpu_write(3'd4, 32'h1);
      cpu_write(3'd2, 32'hA3);
      r = '0;
      for (int i = 0; i < 60 && r[0] == 1'b0; i++) cpu_access(3'd6, 1'b0, 32'h0, r);
      chk("lb_rxstat", r, 32'h1);
      cpu_read(3'd7, 32'hA3, "lb_rxdata");
      cpu_read(3'd6, 32'h0, "lb_rxstat_clr");
      wait_cycles(8);
      loopback = 1'b0;

      // 0x11: not ready one cycle before its completion
      fork
         drive_frame(8'h11, 1'b1);
         begin
            wait_cycles(40);
            cpu_read(3'd6, 32'h0, "rx_early");
         end
      join
      cpu_read(3'd6, 32'h1, "rx_11_ready");
      wait_cycles(3);
      drive_frame(8'h22, 1'b1);
      wait_cycles(3);
      cpu_read(3'd6, 32'h3, "ovr_stat");
      cpu_read(3'd6, 32'h1, "ovr_stat2");
      cpu_read(3'd7, 32'h22, "ovr_data");
      cpu_read(3'd6, 32'h0, "ovr_clr");

      drive_frame(8'h5A, 1'b0);
      wait_cycles(20);
      cpu_read(3'd6, 32'h0, "frame_err");

      rxd_drv = 1'b0;
      wait_cycles(1);
      rxd_drv = 1'b1;
      wait_cycles(60);
      cpu_read(3'd6, 32'h0, "glitch");

      // read of RXDATA in the completion cycle of the next byte
      drive_frame(8'h3C, 1'b1);
      wait_cycles(3);
      cpu_read(3'd6, 32'h1, "pend_3c");
      fork
         drive_frame(8'h77, 1'b1);
         begin
            wait_cycles(40);
            cpu_read(3'd7, 32'h3C, "same_cyc_old");
         end
      join
      cpu_read(3'd6, 32'h1, "same_cyc_stat");
      cpu_read(3'd7, 32'h77, "same_cyc_new");
      cpu_read(3'd6, 32'h0, "same_cyc_clr");

      // SOFTRESET mid-frame with a byte pending
      drive_frame(8'h99, 1'b1);
      wait_cycles(3);
      cpu_write(3'd2, 32'h00);
      wait_cycles(10);
      chk("sr_txd_busy", 32'(txd), 32'd0);
      cpu_write(3'd0, 32'h1);
      chk("sr_txd", 32'(txd), 32'd1);
      cpu_read(3'd5, 32'h1, "sr_txready");
      cpu_read(3'd1, 32'h4, "sr_div");
      cpu_read(3'd3, 32'h0, "sr_txen");
      cpu_read(3'd4, 32'h0, "sr_rxen");
      cpu_read(3'd6, 32'h0, "sr_rxstat");
      wait_cycles(40);
      chk("sr_txd_idle", 32'(txd), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
